// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of the single SDRAM transaction bus.
// One grant per stb/ack transaction, a bus-idle gap between grants, and a hang timeout.
module sdram_port_arbiter #(
  parameter int RELEASE_CYCLES = 2,
  parameter int TIMEOUT        = 1023
) (
  input  logic        clk_p,
  input  logic        rst_n,
  input  logic        sdram_ready,

  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [1:0]  m0_sel,
  input  logic [21:1] m0_adr,
  input  logic [15:0] m0_out,
  output logic [15:0] m0_dat,
  output logic        m0_ack,

  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [1:0]  m1_sel,
  input  logic [21:1] m1_adr,
  input  logic [15:0] m1_out,
  output logic [15:0] m1_dat,
  output logic        m1_ack,

  output logic        s_stb,
  output logic        s_we,
  output logic [1:0]  s_sel,
  output logic [21:1] s_adr,
  output logic [15:0] s_out,
  input  logic [15:0] s_dat,
  input  logic        s_ack,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int REL_W = $clog2(RELEASE_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, REL} state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [9:0]       to_cnt, to_cnt_nxt;
  logic [REL_W-1:0] rel_cnt, rel_cnt_nxt;
  logic             err_nxt;
  logic             owner_stb;
  logic             abort;

  // The grant is a decode of the registered state, so it never glitches mid-cycle.
  assign grant     = {state == GNT1, state == GNT0};
  assign owner_stb = (grant[0] & m0_stb) | (grant[1] & m1_stb);
  assign abort     = (grant != 2'b00) && (to_cnt == 10'(TIMEOUT)) && !s_ack;

  assign s_stb  = owner_stb;
  assign m0_ack = grant[0] & m0_stb & (s_ack | abort);
  assign m1_ack = grant[1] & m1_stb & (s_ack | abort);
  assign m0_dat = (grant[0] && !abort) ? s_dat : 16'h0000;
  assign m1_dat = (grant[1] && !abort) ? s_dat : 16'h0000;

  always_comb begin
    s_we  = 1'b0;
    s_sel = '0;
    s_adr = '0;
    s_out = '0;
    unique case (grant)
      2'b01: begin
        s_we  = m0_we;
        s_sel = m0_sel;
        s_adr = m0_adr;
        s_out = m0_out;
      end
      2'b10: begin
        s_we  = m1_we;
        s_sel = m1_sel;
        s_adr = m1_adr;
        s_out = m1_out;
      end
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_nxt   = state;
    last_nxt    = last;
    to_cnt_nxt  = to_cnt;
    rel_cnt_nxt = rel_cnt;
    err_nxt     = timeout_err;

    unique case (state)
      IDLE: begin
        to_cnt_nxt  = '0;
        rel_cnt_nxt = '0;
        if (sdram_ready && (m0_stb || m1_stb)) begin
          // On a tie the port that did not go last wins.
          if (m0_stb && (!m1_stb || last)) begin
            state_nxt = GNT0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = GNT1;
            last_nxt  = 1'b1;
          end
        end
      end

      GNT0, GNT1: begin
        if (abort) begin
          state_nxt  = REL;
          err_nxt    = 1'b1;
          to_cnt_nxt = '0;
        end else if (!owner_stb) begin
          state_nxt  = REL;
          to_cnt_nxt = '0;
        end else if (s_ack) begin
          to_cnt_nxt = '0;
        end else begin
          to_cnt_nxt = to_cnt + 10'd1;
        end
      end

      REL: begin
        // Keeps the bus quiet long enough for the downstream ack pipeline to drain.
        if (rel_cnt == REL_W'(RELEASE_CYCLES - 1)) begin
          state_nxt   = IDLE;
          rel_cnt_nxt = '0;
        end else begin
          rel_cnt_nxt = rel_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      to_cnt      <= '0;
      rel_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      to_cnt      <= to_cnt_nxt;
      rel_cnt     <= rel_cnt_nxt;
      timeout_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table, directed corner cases,
// and randomized traffic against a transaction-level ownership model.
module tb_sdram_port_arbiter;

  localparam int RELEASE_CYCLES = 2;
  localparam int TIMEOUT        = 1023;

  logic        clk_p = 1'b0;
  logic        rst_n;
  logic        sdram_ready;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [1:0]  m0_sel, m1_sel;
  logic [21:1] m0_adr, m1_adr;
  logic [15:0] m0_out, m1_out, m0_dat, m1_dat;
  logic        m0_ack, m1_ack;
  logic        s_stb, s_we, s_ack;
  logic [1:0]  s_sel;
  logic [21:1] s_adr;
  logic [15:0] s_out, s_dat;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_port_arbiter #(.RELEASE_CYCLES(RELEASE_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .sdram_ready(sdram_ready),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_out(m0_out), .m0_dat(m0_dat), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_out(m1_out), .m1_dat(m1_dat), .m1_ack(m1_ack),
    .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr), .s_out(s_out),
    .s_dat(s_dat), .s_ack(s_ack), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk_p = ~clk_p;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_p);
    #1;
  endtask

  task automatic clear_inputs();
    sdram_ready = 1'b0;
    m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 2'b00; m0_adr = '0; m0_out = '0;
    m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 2'b00; m1_adr = '0; m1_out = '0;
    s_ack = 1'b0; s_dat = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rdy;
    logic       stb0;
    logic       stb1;
    logic       ack;
    logic [4:0] exp;   // {grant, s_stb, m0_ack, m1_ack}
  } vec_t;

  vec_t vt[22];

  // Reference model: who owns the bus, how many quiet cycles remain, who went last.
  int   owner, gap, lastp, waitc;
  bit   err_m;
  bit   stb_r[2], we_r[2], ackp[2];
  logic [1:0]  sel_r[2];
  logic [21:1] adr_r[2];
  logic [15:0] out_r[2];

  initial begin
    int         cnt;
    bit         bad;
    bit         abort_m;
    logic [1:0] eg;
    logic [21:1] ea;
    logic [15:0] eo, ed0, ed1;
    logic [1:0]  es;
    logic        ew, ess, ea0, ea1;

    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b00_0_00};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b01_1_00};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b01_1_10};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b01_0_00};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b00_0_00};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b00_0_00};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b00_0_00};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10_1_00};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b10_1_01};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10_0_00};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b00_0_00};
    vt[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b00_0_00};
    vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b00_0_00};
    vt[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b01_1_00};
    vt[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b01_1_10};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b01_0_00};
    vt[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00_0_00};
    vt[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00_0_00};
    vt[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00_0_00};
    vt[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00_0_00};
    vt[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b00_0_00};
    vt[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b01_1_10};

    // Reset state.
    do_reset();
    #1;
    check("reset_state", 64'({grant, s_stb, m0_ack, m1_ack, timeout_err, s_adr}), 64'(0));

    // Vector table: arbitration, alternation, release gap, sdram_ready gating.
    for (int i = 0; i < 22; i++) begin
      sdram_ready = vt[i].rdy;
      m0_stb      = vt[i].stb0;
      m1_stb      = vt[i].stb1;
      s_ack       = vt[i].ack;
      #1;
      check($sformatf("vec%0d", i), 64'({grant, s_stb, m0_ack, m1_ack}), 64'(vt[i].exp));
      cyc();
    end

    // Port 0 read datapath.
    do_reset();
    sdram_ready = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 21'h000100; m0_sel = 2'b11;
    cyc();
    #1;
    check("rd_grant_adr_we", 64'({grant, s_adr, s_we}), 64'({2'b01, 21'h000100, 1'b0}));
    cyc();
    s_ack = 1'b1; s_dat = 16'h1234;
    #1;
    check("rd_ack_dat", 64'({m0_ack, m0_dat, m1_ack, m1_dat}), 64'({1'b1, 16'h1234, 1'b0, 16'h0000}));
    cyc();
    m0_stb = 1'b0; s_ack = 1'b0;
    cyc();

    // Port 1 write mux, port 0 blocked until the release gap has passed.
    do_reset();
    sdram_ready = 1'b1;
    m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 2'b10; m1_out = 16'hABCD; m1_adr = 21'h1ABCDE;
    m0_adr = 21'h000777;
    cyc();
    #1;
    check("wr_mux", 64'({grant, s_we, s_sel, s_out, s_adr}),
          64'({2'b10, 1'b1, 2'b10, 16'hABCD, 21'h1ABCDE}));
    cyc();
    m0_stb = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (grant != 2'b10 || m0_ack) bad = 1'b1;
      cyc();
    end
    check("hold_grant_mid_txn", 64'(bad), 64'(0));
    s_ack = 1'b1;
    #1;
    check("wr_ack", 64'({m1_ack, m0_ack}), 64'(2'b10));
    cyc();
    m1_stb = 1'b0; s_ack = 1'b0;
    cyc();
    cnt = 0;
    bad = 1'b0;
    while (grant != 2'b01 && cnt < 20) begin
      if (grant != 2'b00 || s_stb) bad = 1'b1;
      cnt++;
      cyc();
    end
    check("release_gap_len", 64'(cnt), 64'(RELEASE_CYCLES + 1));
    check("release_gap_quiet", 64'(bad), 64'(0));
    #1;
    check("m0_after_rel_adr", 64'({grant, s_adr}), 64'({2'b01, 21'h000777}));
    m0_stb = 1'b0;
    cyc();

    // sdram_ready low blocks grants.
    do_reset();
    m0_stb = 1'b1; m0_adr = 21'h000042;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (grant != 2'b00 || s_stb) bad = 1'b1;
      cyc();
    end
    check("not_ready_idle", 64'(bad), 64'(0));
    sdram_ready = 1'b1;
    cyc();
    check("ready_grant", 64'(grant), 64'(2'b01));

    // Timeout: no s_ack ever returns.
    cnt = 0;
    forever begin
      #1;
      if (m0_ack || grant != 2'b01 || cnt >= 2000) break;
      cnt++;
      cyc();
    end
    check("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
    check("timeout_ack_dat", 64'({m0_ack, m0_dat, timeout_err}), 64'({1'b1, 16'h0000, 1'b0}));
    cyc();
    #1;
    check("timeout_after", 64'({timeout_err, grant, s_stb, m0_ack}), 64'({1'b1, 2'b00, 1'b0, 1'b0}));
    m0_stb = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    #1;
    check("timeout_err_sticky", 64'(timeout_err), 64'(1));
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    check("timeout_err_cleared", 64'(timeout_err), 64'(0));

    // Reset during a port 1 grant.
    do_reset();
    sdram_ready = 1'b1; m1_stb = 1'b1;
    cyc();
    #1;
    check("gnt1_active", 64'({grant, s_stb}), 64'({2'b10, 1'b1}));
    rst_n = 1'b0; s_ack = 1'b1;
    cyc();
    #1;
    check("reset_mid_txn", 64'({grant, s_stb, m1_ack}), 64'(0));
    rst_n = 1'b1; s_ack = 1'b0; m0_stb = 1'b1;
    cyc();
    #1;
    check("tie_after_reset", 64'(grant), 64'(2'b01));
    m0_stb = 1'b0; m1_stb = 1'b0;
    cyc();

    // Randomized traffic against the ownership model.
    do_reset();
    owner = -1; gap = 0; lastp = 1; waitc = 0; err_m = 1'b0;
    for (int p = 0; p < 2; p++) begin
      stb_r[p] = 1'b0; ackp[p] = 1'b0; we_r[p] = 1'b0;
      sel_r[p] = '0; adr_r[p] = '0; out_r[p] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (stb_r[p] && ackp[p]) stb_r[p] = 1'b0;
        else if (stb_r[p] && $urandom_range(0, 99) < 2) stb_r[p] = 1'b0;
        else if (!stb_r[p] && $urandom_range(0, 99) < 40) begin
          stb_r[p] = 1'b1;
          we_r[p]  = 1'($urandom);
          sel_r[p] = 2'($urandom);
          adr_r[p] = 21'($urandom);
          out_r[p] = 16'($urandom);
        end
      end
      m0_stb = stb_r[0]; m0_we = we_r[0]; m0_sel = sel_r[0]; m0_adr = adr_r[0]; m0_out = out_r[0];
      m1_stb = stb_r[1]; m1_we = we_r[1]; m1_sel = sel_r[1]; m1_adr = adr_r[1]; m1_out = out_r[1];
      s_ack       = ($urandom_range(0, 99) < 30);
      s_dat       = 16'($urandom);
      sdram_ready = ($urandom_range(0, 99) < 85);
      #1;

      abort_m = (owner >= 0) && (waitc == TIMEOUT) && !s_ack;
      eg  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      ess = (owner >= 0) && stb_r[owner];
      ea0 = (owner == 0) && stb_r[0] && (s_ack || abort_m);
      ea1 = (owner == 1) && stb_r[1] && (s_ack || abort_m);
      ed0 = (owner == 0 && !abort_m) ? s_dat : 16'h0000;
      ed1 = (owner == 1 && !abort_m) ? s_dat : 16'h0000;
      ew  = (owner >= 0) ? we_r[owner]  : 1'b0;
      es  = (owner >= 0) ? sel_r[owner] : 2'b00;
      ea  = (owner >= 0) ? adr_r[owner] : 21'h0;
      eo  = (owner >= 0) ? out_r[owner] : 16'h0;

      check($sformatf("rnd%0d_ctl", c), 64'({grant, s_stb, m0_ack, m1_ack, timeout_err}),
            64'({eg, ess, ea0, ea1, err_m}));
      check($sformatf("rnd%0d_bus", c), 64'({s_we, s_sel, s_adr, s_out}), 64'({ew, es, ea, eo}));
      check($sformatf("rnd%0d_dat", c), 64'({m0_dat, m1_dat}), 64'({ed0, ed1}));
      ackp[0] = ea0;
      ackp[1] = ea1;

      if (owner >= 0) begin
        if (abort_m || !stb_r[owner]) begin
          if (abort_m) err_m = 1'b1;
          owner = -1;
          gap   = RELEASE_CYCLES;
          waitc = 0;
        end else begin
          waitc = s_ack ? 0 : waitc + 1;
        end
      end else if (gap > 0) begin
        gap--;
      end else if (sdram_ready && (stb_r[0] || stb_r[1])) begin
        if (stb_r[0] && stb_r[1]) owner = (lastp == 0) ? 1 : 0;
        else                      owner = stb_r[0] ? 0 : 1;
        lastp = owner;
        waitc = 0;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-port round-robin arbiter in front of the single SDRAM transaction bus (stb/we/sel/adr/out/dat/ack, word address [21:1]).
- Port 0 is the CPU/bus side; port 1 is a secondary master (DMA or video refill).
- Holds each grant for one complete stb/ack transaction, enforces a bus-idle gap between grants, and breaks hung transactions with a timeout.

Parameters:
- RELEASE_CYCLES, 2, minimum s_stb-low cycles between grants; covers the 2-stage ack delay pipeline downstream.
- TIMEOUT, 1023, cycles without s_ack before a granted transaction is aborted; counter is 10 bits.

Ports:
- clk_p  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sdram_ready  in  1  SDRAM controller initialisation complete.
- m0_stb  in  1  port 0 transaction strobe; held until m0_ack is seen.
- m0_we  in  1  port 0 write enable.
- m0_sel  in  2  port 0 byte select.
- m0_adr  in  21  port 0 word address [21:1].
- m0_out  in  16  port 0 write data.
- m0_dat  out  16  port 0 read data.
- m0_ack  out  1  port 0 acknowledge.
- m1_stb, m1_we, m1_sel, m1_adr, m1_out, m1_dat, m1_ack: same as port 0, for port 1.
- s_stb  out  1  strobe to the SDRAM controller.
- s_we  out  1  write enable to the controller.
- s_sel  out  2  byte select to the controller.
- s_adr  out  21  word address to the controller.
- s_out  out  16  write data to the controller.
- s_dat  in  16  read data from the controller.
- s_ack  in  1  acknowledge from the controller.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  sticky; set when a transaction is aborted by timeout.

Behaviour:
- Reset (rst_n low at a clk_p edge): state=IDLE, grant=00, last=1 (port 0 wins the first tie), release counter=0, timeout counter=0, timeout_err=0. Reset mid-transaction drops s_stb the next cycle with no ack.
- Outputs are combinational from the registered grant:
  - s_stb = OR over N of (grant[N] & mN_stb).
  - s_we/s_sel/s_adr/s_out are muxed from the granted port; all zero when grant=00.
  - mN_ack = grant[N] & mN_stb & (s_ack | abort).
  - m0_dat = m1_dat = s_dat while that port is granted, else 0.
- FSM states: IDLE, GNT0, GNT1, REL.
  - IDLE: when sdram_ready=1 and any mN_stb=1, pick the winner. A single requester wins outright. If both request, the winner is the port != last. Next state is GNTn, grant set, last<=n. The first s_stb cycle is 1 cycle after the request is sampled. If sdram_ready=0, stay in IDLE and grant nothing.
  - GNTn: the timeout counter increments each cycle s_ack=0 and clears on s_ack.
    - When mN_stb falls (requester ends its cycle after ack), go to REL and clear grant the same edge.
    - If mN_stb drops without any ack (master abandons), still go to REL.
  - REL: s_stb=0. Count RELEASE_CYCLES cycles, then go to IDLE. Requests arriving during REL are held by the masters and arbitrated in IDLE.
- Timeout: when the counter reaches TIMEOUT with s_ack still 0:
  - abort=1 for exactly one cycle, giving a one-cycle mN_ack with mN_dat=16'h0000.
  - timeout_err<=1 (sticky until reset).
  - Next state is REL; s_stb falls on that edge.
- sdram_ready falling during GNTn does not interrupt the current transaction; only new grants are blocked.
- s_ack arriving while grant=00 or in REL is ignored; no mN_ack is generated.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1. No port waits more than one foreign transaction plus RELEASE_CYCLES+1 cycles.

Test Plan:
- Reset, sdram_ready=1, m0_stb=1 read at adr 21'h000100 → grant=01 on the next cycle, s_adr=21'h000100, s_we=0. Controller returns s_ack with s_dat=16'h1234 → m0_ack=1, m0_dat=16'h1234, m1_ack=0.
- m0_stb and m1_stb asserted together after reset → port 0 first. After m0 drops stb, s_stb stays low 2 cycles, then grant=10. Repeat → sequence 0,1,0,1.
- m1 write, sel=2'b10, out=16'hABCD → s_sel=2'b10, s_out=16'hABCD, s_we=1. m0 requests mid-transaction → m0 is not granted until REL completes.
- Hold sdram_ready=0 with m0_stb=1 for 50 cycles → grant=00, s_stb=0 throughout. Raise sdram_ready → grant=01 on the next cycle.
- Grant m0 with s_ack never returned → after 1023 cycles, one-cycle m0_ack with m0_dat=0 and timeout_err=1. timeout_err stays 1 until rst_n is pulsed low.
- Assert rst_n=0 during GNT1 with s_stb=1 → next edge grant=00, s_stb=0, m1_ack=0. After release, m0 wins the tie.
